// File: rtl/fact_ctrl.sv
// fact_ctrl: start/done sequencer for the factorial datapath.
// Loads the operand into the external down-counter, then repeatedly
// multiplies the running product by the counter value using a serial
// shift-add multiplier, decrementing the counter between passes.
// The product is truncated to OUT_SIZE bits after every multiply, and a
// sticky flag records whether any of those multiplies lost high bits.
module fact_ctrl #(
    parameter int SIZE     = 8,
    parameter int OUT_SIZE = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [SIZE-1:0]     n,
    input  logic [SIZE-1:0]     cnt_q,
    output logic                cnt_en,
    output logic                cnt_load,
    output logic [SIZE-1:0]     cnt_d,
    output logic                busy,
    output logic                done,
    output logic [OUT_SIZE-1:0] result,
    output logic                ovf
);

    // Accumulator holds a full OUT_SIZE x SIZE product.
    localparam int ACC_W = OUT_SIZE + SIZE;
    // Bit index must reach SIZE-1.
    localparam int IDX_W = $clog2(SIZE) + 1;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        CHECK,
        MUL,
        DEC,
        DONE
    } state_t;

    state_t state_q;
    state_t state_d;

    // Control registers (reset)
    logic [SIZE-1:0]     n_q;
    logic [OUT_SIZE-1:0] result_q;
    logic                ovf_q;

    // Multiplier datapath registers (always initialised in CHECK, no reset)
    logic [OUT_SIZE-1:0] mcand_q;
    logic [SIZE-1:0]     mplier_q;
    logic [ACC_W-1:0]    acc_q;
    logic [IDX_W-1:0]    idx_q;

    logic [ACC_W-1:0]    addend;
    logic [ACC_W-1:0]    acc_sum;
    logic                mul_last;
    logic                cnt_le1;

    // Low OUT_SIZE bits of a full product: the value carried to the next step.
    function automatic logic [OUT_SIZE-1:0] trunc_prod(input logic [ACC_W-1:0] p);
        return p[OUT_SIZE-1:0];
    endfunction

    // True when a full product has bits above OUT_SIZE that truncation drops.
    function automatic logic prod_ovf(input logic [ACC_W-1:0] p);
        return |p[ACC_W-1:OUT_SIZE];
    endfunction

    // Partial-product add for the current multiplier bit; on the last bit
    // this sum is the complete product.
    always_comb begin
        addend   = mplier_q[0] ? (ACC_W'(mcand_q) << idx_q) : '0;
        acc_sum  = acc_q + addend;
        mul_last = (idx_q == IDX_W'(SIZE - 1));
        cnt_le1  = (cnt_q <= SIZE'(1));
    end

    // State register; reset returns to IDLE immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic and state-decoded control outputs.
    always_comb begin
        state_d  = state_q;
        cnt_en   = 1'b0;
        cnt_load = 1'b0;
        busy     = 1'b1;
        done     = 1'b0;
        case (state_q)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                cnt_en   = 1'b1;
                cnt_load = 1'b1;
                state_d  = CHECK;
            end
            CHECK: begin
                state_d = cnt_le1 ? DONE : MUL;
            end
            MUL: begin
                if (mul_last) begin
                    state_d = DEC;
                end
            end
            DEC: begin
                cnt_en  = 1'b1;
                state_d = CHECK;
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: begin
                busy    = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    // Operand capture, running product and sticky overflow.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            n_q      <= '0;
            result_q <= '0;
            ovf_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        n_q <= n;
                    end
                end
                LOAD: begin
                    result_q <= OUT_SIZE'(1);
                    ovf_q    <= 1'b0;
                end
                MUL: begin
                    if (mul_last) begin
                        result_q <= trunc_prod(acc_sum);
                        ovf_q    <= ovf_q | prod_ovf(acc_sum);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Serial shift-add multiplier: result x cnt_q, one multiplier bit per cycle.
    always_ff @(posedge clk) begin
        case (state_q)
            CHECK: begin
                mcand_q  <= result_q;
                mplier_q <= cnt_q;
                acc_q    <= '0;
                idx_q    <= '0;
            end
            MUL: begin
                acc_q    <= acc_sum;
                mplier_q <= mplier_q >> 1;
                idx_q    <= idx_q + IDX_W'(1);
            end
            default: begin
            end
        endcase
    end

    assign cnt_d  = n_q;
    assign result = result_q;
    assign ovf    = ovf_q;

endmodule

// File: tb/tb_fact_ctrl.sv
// Testbench for fact_ctrl: directed scenarios followed by random operands,
// checked against a plain-arithmetic factorial model. The external
// down-counter is modelled here as it is wired in the real design.
module tb_fact_ctrl;

    localparam int SIZE     = 8;
    localparam int OUT_SIZE = 32;

    logic                clk   = 1'b0;
    logic                rst   = 1'b1;
    logic                start = 1'b0;
    logic [SIZE-1:0]     n     = '0;
    logic [SIZE-1:0]     cnt_q = '0;
    logic                cnt_en;
    logic                cnt_load;
    logic [SIZE-1:0]     cnt_d;
    logic                busy;
    logic                done;
    logic [OUT_SIZE-1:0] result;
    logic                ovf;

    int n_asrt = 0;
    int n_fail = 0;

    fact_ctrl #(.SIZE(SIZE), .OUT_SIZE(OUT_SIZE)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .n        (n),
        .cnt_q    (cnt_q),
        .cnt_en   (cnt_en),
        .cnt_load (cnt_load),
        .cnt_d    (cnt_d),
        .busy     (busy),
        .done     (done),
        .result   (result),
        .ovf      (ovf)
    );

    always #5 clk = ~clk;

    // External loadable down-counter (no reset).
    always @(posedge clk) begin
        if (cnt_en) begin
            cnt_q <= cnt_load ? cnt_d : cnt_q - 8'd1;
        end
    end

    task automatic chk(input string tag, input longint unsigned obs, input longint unsigned exp);
        n_asrt++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // n! mod 2^OUT_SIZE, multiplying by n, n-1, ..., 2 in that order and
    // flagging any step whose full product needs more than OUT_SIZE bits.
    function automatic void ref_fact(input int nv, output longint unsigned r, output bit ov);
        longint unsigned p;
        r  = 1;
        ov = 1'b0;
        for (int k = nv; k >= 2; k--) begin
            p = r * longint'(k);
            if ((p >> OUT_SIZE) != 0) ov = 1'b1;
            r = p & 64'h0000_0000_FFFF_FFFF;
        end
    endfunction

    // One transaction, entered #1 after a rising edge with the DUT in IDLE.
    task automatic do_run(input string tag, input int nv, input int n_mid, input bit hold,
                          input longint unsigned exp_res, input bit exp_ovf);
        int k;
        int lat;
        int en_cnt;
        int bad_busy;
        bit seen;
        logic [31:0] nv_v;
        logic [31:0] nm_v;
        nv_v  = nv;
        n     = nv_v[SIZE-1:0];
        start = 1'b1;
        @(posedge clk); #1;
        if (!hold) start = 1'b0;
        chk({tag, "_load_ctl"}, {cnt_en, cnt_load, busy, done}, 4'b1110);
        if (n_mid >= 0) begin
            nm_v = n_mid;
            n    = nm_v[SIZE-1:0];
        end
        k        = 1;
        en_cnt   = (cnt_en === 1'b1) ? 1 : 0;
        bad_busy = 0;
        seen     = 1'b0;
        while (!seen && k < 400) begin
            @(posedge clk); #1;
            k++;
            if (busy !== 1'b1) bad_busy++;
            if (cnt_en === 1'b1) en_cnt++;
            if (done === 1'b1) seen = 1'b1;
        end
        lat = 3 + ((nv > 1) ? (nv - 1) * (SIZE + 2) : 0);
        chk({tag, "_done_seen"}, seen, 1);
        chk({tag, "_latency"}, k, lat);
        chk({tag, "_busy_hi"}, bad_busy, 0);
        chk({tag, "_cnt_en_cycles"}, en_cnt, 1 + ((nv > 1) ? nv - 1 : 0));
        chk({tag, "_result"}, result, exp_res);
        chk({tag, "_ovf"}, ovf, exp_ovf);
        chk({tag, "_cnt_d"}, cnt_d, nv);
        @(posedge clk); #1;
        chk({tag, "_idle_ctl"}, {busy, done, cnt_en}, 3'b000);
        chk({tag, "_result_hold"}, result, exp_res);
    endtask

    initial begin
        longint unsigned r;
        bit ov;
        int nv;

        // Reset state
        #3;
        chk("rst_ctl", {busy, done, cnt_en, cnt_load, ovf}, 5'b00000);
        chk("rst_result", result, 0);
        chk("rst_cnt_d", cnt_d, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // Directed operands
        do_run("n5", 5, -1, 1'b0, 120, 1'b0);
        do_run("n0", 0, -1, 1'b0, 1, 1'b0);
        do_run("n1", 1, -1, 1'b0, 1, 1'b0);
        do_run("n12", 12, -1, 1'b0, 479001600, 1'b0);
        do_run("n13", 13, -1, 1'b0, 1932053504, 1'b1);
        do_run("n4", 4, -1, 1'b0, 24, 1'b0);

        // start held high, n changed mid-run, back-to-back second run
        do_run("hold5", 5, 3, 1'b1, 120, 1'b0);
        do_run("hold3", 3, -1, 1'b0, 6, 1'b0);

        // Asynchronous reset in the middle of a multiply pass
        n     = 8'd6;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("mid_busy", busy, 1);
        #2;
        rst = 1'b1;
        #1;
        chk("mid_rst_ctl", {busy, done, cnt_en, cnt_load, ovf}, 5'b00000);
        chk("mid_rst_result", result, 0);
        chk("mid_rst_cnt_d", cnt_d, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        do_run("n6", 6, -1, 1'b0, 720, 1'b0);

        // Random operands against the reference model
        repeat (8) begin
            nv = int'($urandom_range(0, 14));
            ref_fact(nv, r, ov);
            do_run("rnd", nv, -1, 1'b0, r, ov);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end

endmodule

// File: doc/fact_ctrl.md
# fact_ctrl

Sequencing controller and iterative multiplier for the factorial datapath. It accepts an operand `n` under a start/done handshake and loads `n` into the external down-counter. On each step it multiplies the running product by the counter value with a shift-add multiplier, then decrements the counter, and finishes when the counter value is at most 1. It sits directly upstream of the `cnt` instance, driving its `en`/`load_cnt`/`d` and consuming its `q`, and presents `n!` to the rest of the design.

## Interface
- `SIZE`, 8: width of `n` and of the counter bus.
- `OUT_SIZE`, 32: width of the product/result register.

- `clk`  in  1  sole clock; all state updates on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  request; sampled only in IDLE.
- `n`  in  SIZE  operand; captured on the accepted `start`.
- `cnt_q`  in  SIZE  counter output (`cnt.q`).
- `cnt_en`  out  1  counter enable (`cnt.en`).
- `cnt_load`  out  1  counter load select (`cnt.load_cnt`).
- `cnt_d`  out  SIZE  counter load value (`cnt.d`) = captured `n`.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  single-cycle pulse: `result` and `ovf` are final.
- `result`  out  OUT_SIZE  n! mod 2^OUT_SIZE; holds until the next accepted start.
- `ovf`  out  1  sticky: some intermediate product exceeded OUT_SIZE bits.

## Operation
- States: IDLE, LOAD, CHECK, MUL, DEC, DONE.
- Reset values: state=IDLE, `busy`=0, `done`=0, `cnt_en`=0, `cnt_load`=0, `result`=0, `ovf`=0, `cnt_d`=0. The counter has no reset; it is always loaded before use.
- `cnt_en`, `cnt_load`, `busy` and `done` are decoded from the state register, with no extra register stage.
- IDLE: when `start`=1, capture `n`, go to LOAD. When `start`=0, stay.
- LOAD:
  - `cnt_en`=1, `cnt_load`=1.
  - `result` <= 1, `ovf` <= 0.
  - Next state is CHECK.
- CHECK: `cnt_q` now reflects the last load or decrement.
  - If `cnt_q` <= 1, go to DONE.
  - Otherwise init the multiplier and go to MUL:
    - multiplicand = `result`
    - multiplier = `cnt_q`
    - acc = 0 (OUT_SIZE+SIZE bits)
    - bit count = SIZE
- MUL: exactly SIZE cycles.
  - Each cycle: if multiplier[0], acc += multiplicand shifted by the current bit index. Then shift the multiplier right.
  - On the last cycle: `result` <= acc[OUT_SIZE-1:0], and `ovf` <= `ovf` | (acc[OUT_SIZE+SIZE-1:OUT_SIZE] != 0). Next state is DEC.
- DEC: `cnt_en`=1, `cnt_load`=0, so the counter decrements by 1. Next state is CHECK.
- DONE: `done`=1 for one cycle, then go to IDLE.
- Arithmetic: the product is truncated to OUT_SIZE bits after every step. `result` is therefore exactly n! mod 2^OUT_SIZE.
- `start` while `busy`=1: ignored; the captured `n` is unchanged.
- `n`=0 or `n`=1: `result`=1, `ovf`=0, no MUL pass.
- Reset mid-operation: state returns to IDLE immediately (asynchronously). `cnt_en` drops in the same instant, and `result`/`ovf` clear.

## Timing
- Define T as the cycle in which IDLE samples `start`=1.
  - LOAD occupies cycle T+1.
  - The first CHECK occupies T+2.
- Each iteration costs SIZE+2 cycles (CHECK, SIZE×MUL, DEC). There are max(n-1,0) iterations.
- `done` is high in cycle T+3+max(n-1,0)·(SIZE+2).
  - With SIZE=8: n≤1 gives T+3; n=2 gives T+13; n=5 gives T+43.
- `busy` rises in T+1 and falls in the cycle after DONE.
  - A new `start` is accepted there at the earliest, one cycle after `done`.
- `result` may change during operation. It is valid only from the `done` cycle onward.

## Test plan
- Basic factorial (SIZE=8, OUT_SIZE=32): n=5, `start` pulsed at T -> `done` at T+43, `result`=120, `ovf`=0. Bench checks `busy` is high from T+1 through T+43.
- Edge operands: n=0 and n=1 -> `done` at T+3, `result`=1, `ovf`=0, `cnt_en` high only in LOAD.
- Largest non-overflowing operand: n=12 -> `result`=479001600, `ovf`=0.
- Overflow: n=13 -> `result`=1932053504, `ovf`=1. Then n=4 -> `result`=24 and `ovf` back to 0.
- `start` held high throughout with n changed mid-run (5 -> 3) -> first run returns 120. A second run starts the cycle after `done`, captures 3, and returns 6.
- Reset mid-MUL of n=6 -> all outputs at reset values in the same cycle and `cnt_en`=0. A fresh `start` with n=6 then returns 720.
